// File: rtl/adc_sample_decimator.sv
// Offset-binary ADC front end: converts to two's complement and boxcar-averages
// 2^R valid samples per output. Optional rail-code detection under ADC_SAT_DETECT_EN.
module adc_sample_decimator #(
  parameter  int DATA_WIDTH     = 12,
  parameter  int MAX_LOG2_RATIO = 4,
  localparam int ACC_WIDTH      = DATA_WIDTH + MAX_LOG2_RATIO,
  localparam int RW             = $clog2(MAX_LOG2_RATIO + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [RW-1:0]         log2_ratio,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_clip
);

  logic signed [DATA_WIDTH-1:0]     s;
  logic signed [ACC_WIDTH-1:0]      s_ext;
  logic signed [ACC_WIDTH-1:0]      acc;
  logic signed [ACC_WIDTH-1:0]      sum;
  logic        [DATA_WIDTH-1:0]     avg;
  logic        [MAX_LOG2_RATIO-1:0] cnt;
  logic        [MAX_LOG2_RATIO-1:0] cnt_last;
  logic        [RW-1:0]             r_l;
  logic        [RW-1:0]             r_clamp;
  logic        [RW-1:0]             r_eff;
  logic                             first;
  logic                             window_end;

  // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
  always_comb begin
    s        = {~in_data[DATA_WIDTH-1], in_data[DATA_WIDTH-2:0]};
    s_ext    = {{MAX_LOG2_RATIO{s[DATA_WIDTH-1]}}, s};
    r_clamp  = (log2_ratio > RW'(MAX_LOG2_RATIO)) ? RW'(MAX_LOG2_RATIO) : log2_ratio;
    first    = (cnt == '0);
    // The first sample of a window already uses the ratio it is about to latch.
    r_eff    = first ? r_clamp : r_l;
    cnt_last = ~({MAX_LOG2_RATIO{1'b1}} << r_eff);
    window_end = in_valid && (cnt == cnt_last);
    sum      = acc + s_ext;
    avg      = DATA_WIDTH'(sum >>> r_eff);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      cnt       <= '0;
      r_l       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (first) r_l <= r_clamp;
        if (window_end) begin
          out_data  <= avg;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef ADC_SAT_DETECT_EN
  logic rail;
  logic clip_flag;

  assign rail = (in_data == '0) || (in_data == '1);

  // Sticky per-window flag; out_clip snapshots it alongside out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_flag <= 1'b0;
      out_clip  <= 1'b0;
    end else if (in_valid) begin
      if (window_end) begin
        out_clip  <= clip_flag | rail;
        clip_flag <= 1'b0;
      end else begin
        clip_flag <= clip_flag | rail;
      end
    end
  end
`else
  assign out_clip = 1'b0;
`endif

endmodule

// File: tb/tb_adc_sample_decimator.sv
// Self-checking bench for adc_sample_decimator: vector table, hand sequences and
// random windows, with a pulse scoreboard checking data, clip flag and latency.
module tb_adc_sample_decimator;
  localparam int W    = 12;
  localparam int MAXR = 4;
  localparam int RW   = 3;
`ifdef ADC_SAT_DETECT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [RW-1:0] log2_ratio;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_clip;

  adc_sample_decimator #(.DATA_WIDTH(W), .MAX_LOG2_RATIO(MAXR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .log2_ratio(log2_ratio), .out_valid(out_valid), .out_data(out_data),
    .out_clip(out_clip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         clip;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef logic [W-1:0] win_t [16];

  typedef struct {
    logic [2:0]   ratio;
    int           n;
    logic [W-1:0] base;
    logic [W-1:0] step;
    logic [W-1:0] exp_data;
    logic         exp_clip;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every pulse must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e.data));
        check("out_clip", 32'(out_clip), 32'(mon_e.clip));
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int bubbles);
    repeat (bubbles) begin
      @(posedge clk);
      #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic expect_pulse(input logic [W-1:0] d, input logic c);
    sb.push_back('{data: d, clip: SAT & c, cyc: cyc});
  endtask

  task automatic run_window(input logic [2:0] ratio, input int n, input win_t smp,
                            input logic [W-1:0] exp_d, input logic exp_c, input bit scramble);
    for (int i = 0; i < n; i++) begin
      if (i == 0) log2_ratio = ratio;
      send(smp[i], int'($urandom_range(0, 2)));
      if (scramble) log2_ratio = RW'($urandom);
      if (i == n - 1) expect_pulse(exp_d, exp_c);
    end
  endtask

  function automatic void model(input win_t smp, input int n, input int r,
                                output logic [W-1:0] d, output logic c);
    int sum = 0;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      sum += int'(smp[i]) - 2048;
      if (smp[i] == 12'h000 || smp[i] == 12'hFFF) c = 1'b1;
    end
    sum = sum >>> r;
    d   = sum[W-1:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    win_t         smp;
    logic [W-1:0] md;
    logic         mc;
    int           r;
    int           n;

    tbl[0]  = '{3'd0,  1, 12'h800, 12'h000, 12'h000, 1'b0};
    tbl[1]  = '{3'd0,  1, 12'hFFF, 12'h000, 12'h7FF, 1'b1};
    tbl[2]  = '{3'd0,  1, 12'h000, 12'h000, 12'h800, 1'b1};
    tbl[3]  = '{3'd2,  4, 12'h810, 12'h010, 12'h028, 1'b0};
    tbl[4]  = '{3'd1,  2, 12'h7FF, 12'h000, 12'hFFF, 1'b0};
    tbl[5]  = '{3'd1,  2, 12'h7FF, 12'h001, 12'hFFF, 1'b0};
    tbl[6]  = '{3'd1,  2, 12'h000, 12'h000, 12'h800, 1'b1};
    tbl[7]  = '{3'd7, 16, 12'h800, 12'h001, 12'h007, 1'b0};
    tbl[8]  = '{3'd4, 16, 12'h000, 12'h000, 12'h800, 1'b1};
    tbl[9]  = '{3'd3,  8, 12'hFFF, 12'h000, 12'h7FF, 1'b1};
    tbl[10] = '{3'd2,  4, 12'h810, 12'h000, 12'h010, 1'b0};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    log2_ratio = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_clip",  32'(out_clip),  32'd0);

    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < 16; i++) smp[i] = tbl[k].base + W'(i) * tbl[k].step;
      run_window(tbl[k].ratio, tbl[k].n, smp, tbl[k].exp_data, tbl[k].exp_clip, 1'b1);
    end

    // Rail code inside an R=2 window, then a clean window clears the flag.
    smp = '{default: 12'h800};
    smp[1] = 12'hFFF;
    run_window(3'd2, 4, smp, 12'h1FF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("clip_held", 32'(out_clip), 32'(SAT));
    check("data_held", 32'(out_data), 32'h1FF);
    smp = '{default: 12'h810};
    run_window(3'd2, 4, smp, 12'h010, 1'b0, 1'b0);

    // Ratio drops 2->0 mid-window: window still needs 4 samples, then passthrough.
    log2_ratio = 3'd2;
    send(12'h900, 0);
    send(12'h900, 1);
    log2_ratio = 3'd0;
    send(12'h900, 0);
    send(12'h900, 0);
    expect_pulse(12'h100, 1'b0);
    send(12'h880, 0);
    expect_pulse(12'h080, 1'b0);
    send(12'h7F0, 0);
    expect_pulse(12'hFF0, 1'b0);

    // Reset after 3 of 4 samples, with a colliding valid sample that must be dropped.
    log2_ratio = 3'd2;
    send(12'h900, 0);
    send(12'h900, 0);
    send(12'h000, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'h000;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data",  32'(out_data),  32'd0);
    check("rst_mid_out_clip",  32'(out_clip),  32'd0);
    for (int i = 0; i < 4; i++) send(12'h900, 0);
    expect_pulse(12'h100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_data_held", 32'(out_data),  32'h100);
    check("post_rst_valid_low", 32'(out_valid), 32'd0);

    // Random windows against the arithmetic model.
    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 7));
      n = 1 << ((r > MAXR) ? MAXR : r);
      for (int i = 0; i < 16; i++)
        smp[i] = ($urandom_range(0, 15) == 0) ? 12'hFFF : W'($urandom);
      model(smp, n, (r > MAXR) ? MAXR : r, md, mc);
      run_window(3'(r), n, smp, md, mc, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_pulses", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
